// File: rtl/serv_pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serv_pc_pkg                                                            |
// | Shared constants and mask helpers for the digit-serial PC unit.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package serv_pc_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int          PC_W = 32;
  localparam logic [31:0] INC4 = 32'd4;
  localparam logic [31:0] INC2 = 32'd2;

  // Mask of the immediate bits that survive for U-type (absolute index >= 12),
  // shifted so that the current digit sits in the low bits.
  function automatic logic [31:0] imm_mask(input logic [5:0] bitpos);
    return 32'hFFFF_F000 >> bitpos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serv_digit_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serv_digit_adder                                                       |
// | W-bit digit adder with a registered carry between digits.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module serv_digit_adder #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic         r_carry;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, r_carry};
  assign o_sum = w_sum[W-1:0];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_carry <= 1'b0;
    end else if (i_clr) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= w_sum[W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/serv_pc_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serv_pc_seq                                                            |
// | Digit-serial PC unit: builds the next PC in a shadow register over    |
// | 32/W cycles and commits it atomically to o_ibus_adr.                   |
// | Optional: SERV_PC_MISALIGN_EN suppresses commit of misaligned jumps.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module serv_pc_seq
  import serv_pc_pkg::*;
#(
  parameter int          W               = 1,
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter bit          WITH_CSR        = 1'b1,
  parameter bit          WITH_COMPRESSED = 1'b1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic         i_iscomp,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic [W-1:0] o_bad_pc,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_misalign,
  output logic [31:0]  o_ibus_adr
);

  localparam int                NDIG  = PC_W / W;
  localparam int                CNT_W = $clog2(NDIG);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NDIG - 1);
  localparam logic [31:0]       ALIGN = WITH_COMPRESSED ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pc_shift;
  logic [31:0]      r_shadow;
  logic [31:0]      r_adr;
  logic             r_jump, r_jal, r_utype, r_pc_rel, r_trap, r_iscomp;
  logic             r_done, r_misalign;

  logic             w_run, w_start, w_last, w_trap_en, w_misalign_hit;
  logic [5:0]       w_bitpos;
  logic [31:0]      w_inc_full, w_shadow_nx;
  logic [W-1:0]     w_p, w_inc, w_off_a, w_off_b, w_imm_m;
  logic [W-1:0]     w_pp4, w_ppo, w_aligned, w_trap_pc, w_new_pc;

  assign w_run     = (r_state == ST_RUN);
  assign w_start   = (r_state == ST_IDLE) && i_start;
  assign w_last    = w_run && (r_cnt == LAST);
  assign w_bitpos  = 6'(r_cnt) * 6'(W);
  assign w_trap_en = r_trap && WITH_CSR;

  assign w_p        = r_pc_shift[W-1:0];
  assign w_inc_full = (r_iscomp && WITH_COMPRESSED) ? INC2 : INC4;
  assign w_inc      = W'(w_inc_full >> w_bitpos);
  assign w_off_a    = r_pc_rel ? w_p : '0;
  assign w_imm_m    = i_imm & W'(imm_mask(w_bitpos));
  assign w_off_b    = r_utype ? w_imm_m : i_buf;

  serv_digit_adder #(.W(W)) u_add_pc4 (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_en    (w_run),
    .i_a     (w_p),
    .i_b     (w_inc),
    .o_sum   (w_pp4)
  );

  serv_digit_adder #(.W(W)) u_add_off (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_en    (w_run),
    .i_a     (w_off_a),
    .i_b     (w_off_b),
    .o_sum   (w_ppo)
  );

  // Alignment masks are addressed by absolute bit index, so they also work when W=1.
  assign w_aligned = w_ppo & W'(ALIGN >> w_bitpos);
  assign w_trap_pc = i_csr_pc & W'(32'hFFFF_FFFC >> w_bitpos);
  assign w_new_pc  = w_trap_en ? w_trap_pc : (r_jump ? w_aligned : w_pp4);

  assign o_rd     = w_run ? (({W{r_utype}} & w_aligned) | ({W{r_jal}} & w_pp4)) : '0;
  assign o_bad_pc = w_run ? w_aligned : '0;

  always_comb begin
    w_shadow_nx                = r_shadow;
    w_shadow_nx[w_bitpos +: W] = w_new_pc;
  end

`ifdef SERV_PC_MISALIGN_EN
  logic r_tgt_bit1;
  logic w_bit1_here, w_bit1_val;

  // Bit 1 of the unmasked target lives in digit 1 when W=1, else in digit 0.
  if (W == 1) begin : g_bit1_w1
    assign w_bit1_here = (r_cnt == CNT_W'(1));
    assign w_bit1_val  = w_ppo[0];
  end else begin : g_bit1_wide
    assign w_bit1_here = (r_cnt == '0);
    assign w_bit1_val  = w_ppo[1];
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tgt_bit1 <= 1'b0;
    end else if (w_start) begin
      r_tgt_bit1 <= 1'b0;
    end else if (w_run && w_bit1_here) begin
      r_tgt_bit1 <= w_bit1_val;
    end
  end

  assign w_misalign_hit = !WITH_COMPRESSED && r_jump && !w_trap_en && r_tgt_bit1;
`else
  assign w_misalign_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pc_shift <= RESET_PC;
      r_shadow   <= RESET_PC;
      r_adr      <= RESET_PC;
      r_jump     <= 1'b0;
      r_jal      <= 1'b0;
      r_utype    <= 1'b0;
      r_pc_rel   <= 1'b0;
      r_trap     <= 1'b0;
      r_iscomp   <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_RUN;
            r_jump     <= i_jump;
            r_jal      <= i_jal_or_jalr;
            r_utype    <= i_utype;
            r_pc_rel   <= i_pc_rel;
            r_trap     <= i_trap;
            r_iscomp   <= i_iscomp;
            r_pc_shift <= r_adr;
            r_cnt      <= '0;
          end
        end
        default: begin
          r_pc_shift <= r_pc_shift >> W;
          r_shadow   <= w_shadow_nx;
          r_cnt      <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b1;
            r_misalign <= w_misalign_hit;
            if (!w_misalign_hit) begin
              r_adr <= w_shadow_nx;
            end
          end
        end
      endcase
    end
  end

  assign o_busy     = w_run;
  assign o_done     = r_done;
  assign o_misalign = r_misalign;
  assign o_ibus_adr = r_adr;

endmodule
`default_nettype wire

// File: doc/serv_pc_seq.md
Name: serv_pc_seq

Overview:
- Digit-serial program-counter unit for the SERV-class core; successor to the 1-bit PC control block.
- Generalised to a W-bit digit path and owns its own digit counter, so no external cnt0/cnt1/cnt2/cnt12to31 strobes are needed.
- Holds o_ibus_adr stable while a new PC is built in a shadow register, then commits it atomically.
- Sits between decode/CSR (control, immediate and buffer digits in) and the instruction bus (address out).

Parameters:
- W, 1: digit width; legal values 1, 2, 4, 8; NDIG = 32/W digits per pass.
- RESET_PC, 32'd0: PC value loaded on reset.
- WITH_CSR, 1: 0 ties the trap path off (i_trap ignored).
- WITH_COMPRESSED, 1: 1 allows PC+2 and 2-byte-aligned targets; 0 forces 4-byte increment and alignment.

Ports:
- clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  begin one PC-update pass; accepted only in IDLE.
- i_jump  in  1  take pc_plus_offset as next PC.
- i_jal_or_jalr  in  1  o_rd carries PC+4/PC+2.
- i_utype  in  1  offset_b = immediate bits 12..31; o_rd carries pc_plus_offset.
- i_pc_rel  in  1  offset_a = current PC.
- i_trap  in  1  next PC = CSR trap vector.
- i_iscomp  in  1  increment by 2 instead of 4.
- i_imm  in  W  immediate digit, LSD first.
- i_buf  in  W  rs1+imm buffer digit, LSD first.
- i_csr_pc  in  W  mtvec/mepc digit, LSD first.
- o_rd  out  W  rd write-back digit.
- o_bad_pc  out  W  aligned jump-target digit, for mtval.
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse, same cycle as the new o_ibus_adr.
- o_misalign  out  1  see Optional Feature.
- o_ibus_adr  out  32  committed PC.

Behaviour:
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE; o_ibus_adr=RESET_PC; shadow PC=RESET_PC.
  - Digit counter=0; both carries=0.
  - o_busy=0, o_done=0, o_misalign=0; o_rd=0, o_bad_pc=0.
- FSM IDLE->RUN on i_start:
  - Latch i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp into control registers.
  - Load the shift copy of the PC from o_ibus_adr; clear the digit counter and both carries.
  - i_start is ignored in RUN.
- RUN lasts exactly NDIG cycles, digit k (k=0..NDIG-1) per cycle; data inputs are sampled combinationally that cycle.
- Per digit, let p = PC[kW+:W]:
  - pc_plus_4 = p + INC[kW+:W] + c4, where INC = (iscomp & WITH_COMPRESSED) ? 2 : 4; c4 is the registered carry.
  - offset_a = pc_rel ? p : 0.
  - offset_b = utype ? (i_imm masked per bit to absolute bit index ≥12) : i_buf.
  - pc_plus_offset = offset_a + offset_b + co.
  - aligned = pc_plus_offset with bit0 cleared in digit 0; bit1 also cleared when WITH_COMPRESSED=0.
  - new_pc:
    - trap & WITH_CSR: i_csr_pc with bits 0..1 cleared in digit 0.
    - else jump: aligned.
    - else: pc_plus_4.
  - o_rd = (utype & aligned) | (jal_or_jalr & pc_plus_4), combinational; o_bad_pc = aligned.
  - new_pc is written into shadow[kW+:W].
- Commit (registered) on the last digit: next cycle o_ibus_adr<=shadow, o_done=1, state=IDLE.
  - i_start is accepted in that done cycle (back-to-back passes: period NDIG+1 cycles).
- Arithmetic is modulo 2^32; the carry out of the top digit is dropped, so 0xFFFFFFFC+4 wraps to 0.
- Simultaneous trap and jump: trap wins.
- o_ibus_adr never changes except at commit or reset.

Optional Feature:
- Macro SERV_PC_MISALIGN_EN.
- Defined, WITH_COMPRESSED=0, jump taken, and unmasked target bit1=1:
  - o_misalign pulses with o_done.
  - o_ibus_adr keeps the old PC (commit suppressed).
  - o_bad_pc still streams the target digits.
- Undefined: o_misalign is tied 0 and the commit always happens.

Decomposition:
- Package serv_pc_pkg holds:
  - FSM state enum {IDLE, RUN}.
  - Localparams NDIG, CNT_W = $clog2(NDIG), INC4 = 32'd4, INC2 = 32'd2.
  - Function imm_mask(k) returning per-bit masks for bit index ≥12.
- One sub-module, serv_digit_adder: W-bit adder with registered carry, clear input and enable. Instantiated twice (pc_plus_4, pc_plus_offset).

Test Plan (W=4, RESET_PC=32'h64):
- Reset: i_rst_n low 2 cycles, release -> o_ibus_adr=0x64, o_busy=0, o_done=0.
- PC+4: i_start, all controls 0 -> o_busy for 8 cycles, then o_done pulse with o_ibus_adr=0x68; adr stays 0x64 during RUN.
- Compressed: from 0x68, i_iscomp=1 -> 0x6A. With WITH_COMPRESSED=0 -> 0x6C.
- JAL: from 0x68, i_jump=1, i_jal_or_jalr=1, i_pc_rel=1, i_utype=1, i_imm digits of 0x00001000:
  - o_rd stream = 0x0000106C (utype OR jal), o_ibus_adr=0x1068.
  - Check the masking variant with i_utype=0, i_buf=0x100 -> o_ibus_adr=0x168.
- Trap: i_trap=1, i_jump=1, i_csr_pc=0x80000003 -> o_ibus_adr=0x80000000; trap wins over jump.
- Mid-pass reset: i_rst_n low at digit 3 -> o_ibus_adr=0x64, o_busy=0, no o_done. Then i_start -> 0x68.
- Macro build: WITH_COMPRESSED=0, jump to 0x102 -> o_misalign=1 and o_ibus_adr unchanged.
